// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
package spi_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a trailing flop for edge detection.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_prev
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign q      = sync_q[SYNC_DEPTH-1];
    assign q_prev = prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first slave, oversampled in the clk domain, with a one-entry tx buffer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] tx_data_i,
    input  logic            tx_valid_i,
    output logic            tx_ready_o,
    output logic [SIZE-1:0] rx_data_o,
    output logic            rx_valid_o,
    output logic            busy_o,
    output logic            underrun_o,
    output logic            abort_o,
    input  logic            SCLK,
    input  logic            CS,
    input  logic            MOSI,
    output logic            MISO
);

    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    state_t state_q, state_d;

    logic sclk_s, sclk_p, cs_s, cs_p, mosi_s;
    logic [SYNC_DEPTH-1:0] mosi_sync_q;
    logic [1:0] prime_q;
    logic armed_q;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic load_c, rx_shift_c, tx_shift_c, abort_c, cnt_clr_c;

    logic [CNT_W-1:0] cnt_q;
    logic [SIZE-1:0]  rx_shift_q, tx_shift_q, tx_buf_q, rx_data_q;
    logic             tx_empty_q, rx_valid_q, busy_q, underrun_q, abort_q, miso_q;
    logic             wr_c;

    spi_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (SCLK),
        .q      (sclk_s),
        .q_prev (sclk_p)
    );

    spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (CS),
        .q      (cs_s),
        .q_prev (cs_p)
    );

    // MOSI needs no edge detect, only alignment with the SCLK sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_DEPTH-1];

    // Frame starts only after CS has been seen high on real (post-reset) samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q <= '0;
            armed_q <= 1'b0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_p;
    assign sclk_fall = ~sclk_s & sclk_p;
    assign cs_rise   = cs_s & ~cs_p;
    assign cs_fall   = ~cs_s & cs_p & armed_q;
    assign wr_c      = tx_valid_i & tx_empty_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        rx_shift_c = 1'b0;
        tx_shift_c = 1'b0;
        abort_c    = 1'b0;
        cnt_clr_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_c    = 1'b1;
                cnt_clr_c = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_c = 1'b1;
                end else if (sclk_fall) begin
                    if (cnt_q == '0) begin
                        load_c = 1'b1;
                    end else begin
                        tx_shift_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // CS release ends the frame and overrides any same-cycle SCLK edge
        if (state_q != IDLE && cs_rise) begin
            state_d    = IDLE;
            load_c     = 1'b0;
            rx_shift_c = 1'b0;
            tx_shift_c = 1'b0;
            cnt_clr_c  = 1'b1;
            abort_c    = (cnt_q != '0) && (cnt_q != CNT_W'(SIZE));
        end
    end

    // Receive path: bit counter, shift register and completed-word strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            abort_q    <= abort_c;
            busy_q     <= (state_d != IDLE);
            if (cnt_q == CNT_W'(SIZE)) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                cnt_q      <= '0;
            end else if (cnt_clr_c) begin
                cnt_q <= '0;
            end else if (rx_shift_c) begin
                rx_shift_q <= {rx_shift_q[SIZE-2:0], mosi_s};
                cnt_q      <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Transmit path: one-entry buffer, shift register and MISO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf_q   <= '0;
            tx_empty_q <= 1'b1;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (state_d == IDLE) begin
                miso_q <= 1'b0;
            end else if (load_c) begin
                if (!tx_empty_q) begin
                    tx_shift_q <= tx_buf_q;
                    miso_q     <= tx_buf_q[SIZE-1];
                    tx_empty_q <= 1'b1;
                end else begin
                    tx_shift_q <= '0;
                    miso_q     <= 1'b0;
                    underrun_q <= 1'b1;
                end
            end else if (tx_shift_c) begin
                tx_shift_q <= {tx_shift_q[SIZE-2:0], 1'b0};
                miso_q     <= tx_shift_q[SIZE-2];
            end
            // Accepted only while empty, so never collides with a full-buffer load
            if (wr_c) begin
                tx_buf_q   <= tx_data_i;
                tx_empty_q <= 1'b0;
            end
        end
    end

    assign tx_ready_o = tx_empty_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;
    assign abort_o    = abort_q;
    assign MISO       = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master plus an rx scoreboard.
module tb_spi_slave;

    localparam int unsigned SIZE = 8;
    localparam int unsigned HALF = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready_o;
    logic [SIZE-1:0] rx_data_o;
    logic            rx_valid_o;
    logic            busy_o;
    logic            underrun_o;
    logic            abort_o;
    logic            sclk;
    logic            cs;
    logic            mosi;
    logic            miso;

    int assertions = 0;
    int failures   = 0;
    int rx_seen    = 0;
    int und_seen   = 0;
    int abort_seen = 0;

    logic [SIZE-1:0] rx_exp_q[$];
    logic [SIZE-1:0] exp_word;

    spi_slave #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .underrun_o (underrun_o),
        .abort_o    (abort_o),
        .SCLK       (sclk),
        .CS         (cs),
        .MOSI       (mosi),
        .MISO       (miso)
    );

    always #5 clk = ~clk;

    // Scoreboard and strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_seen++;
            assertions++;
            if (rx_exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected: rx_data_o=%h, required no strobe", rx_data_o);
            end else begin
                exp_word = rx_exp_q.pop_front();
                if (rx_data_o !== exp_word) begin
                    failures++;
                    $display("FAIL rx_data: got %h, required %h", rx_data_o, exp_word);
                end
            end
        end
        if (underrun_o) und_seen++;
        if (abort_o) abort_seen++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [SIZE-1:0] d);
        int n;
        n = 0;
        while (tx_ready_o !== 1'b1 && n < 50) begin
            clks(1);
            n++;
        end
        assertions++;
        if (tx_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL write_tx_timeout: tx_ready_o=%b, required 1", tx_ready_o);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic spi_begin();
        sclk = 1'b0;
        cs   = 1'b0;
        clks(HALF);
    endtask

    // Leaves SCLK high after the last rising edge; the caller lowers it or ends the frame
    task automatic spi_xfer(input logic [SIZE-1:0] w, input int nbits, output logic [SIZE-1:0] m);
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = w[SIZE-1-i];
            clks(HALF);
            m[SIZE-1-i] = miso;
            sclk = 1'b1;
            clks(HALF);
        end
    endtask

    // CS released while SCLK is still high, so no trailing word-boundary load occurs
    task automatic spi_end();
        cs = 1'b1;
        clks(HALF);
        sclk = 1'b0;
        mosi = 1'b0;
        clks(HALF);
    endtask

    task automatic check_queue_empty(input string name);
        assertions++;
        if (rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_rx_pending: %0d words outstanding, required 0", name, rx_exp_q.size());
            rx_exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        assertions++;
        if ({tx_ready_o, rx_data_o, rx_valid_o, busy_o, underrun_o, abort_o, miso} !==
            {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s: ready=%b rx=%h valid=%b busy=%b und=%b abort=%b miso=%b, required 1 00 0 0 0 0 0",
                     name, tx_ready_o, rx_data_o, rx_valid_o, busy_o, underrun_o, abort_o, miso);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        sclk     = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        clks(3);
        check_reset_outputs("reset_asserted");
        rst = 1'b1;
        clks(6);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_single_word();
        logic [SIZE-1:0] m;
        int rx0, und0;
        write_tx(8'h55);
        assertions++;
        if (tx_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_drop: tx_ready_o=%b, required 0", tx_ready_o);
        end
        rx0  = rx_seen;
        und0 = und_seen;
        rx_exp_q.push_back(8'hA5);
        spi_begin();
        spi_xfer(8'hA5, SIZE, m);
        spi_end();
        assertions++;
        if (m !== 8'h55) begin
            failures++;
            $display("FAIL single_miso: got %h, required 55", m);
        end
        assertions++;
        if (rx_seen - rx0 != 1) begin
            failures++;
            $display("FAIL single_rx_count: got %0d, required 1", rx_seen - rx0);
        end
        assertions++;
        if (und_seen != und0) begin
            failures++;
            $display("FAIL single_underrun: got %0d pulses, required 0", und_seen - und0);
        end
        assertions++;
        if (rx_data_o !== 8'hA5 || tx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_final: rx=%h ready=%b busy=%b, required a5 1 0", rx_data_o, tx_ready_o, busy_o);
        end
        check_queue_empty("single");
    endtask

    task automatic test_back_to_back();
        logic [SIZE-1:0] m1, m2;
        int rx0, und0;
        write_tx(8'h3C);
        rx0  = rx_seen;
        und0 = und_seen;
        rx_exp_q.push_back(8'h0F);
        rx_exp_q.push_back(8'hF0);
        spi_begin();
        assertions++;
        if (tx_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_after_load: ready=%b busy=%b, required 1 1", tx_ready_o, busy_o);
        end
        write_tx(8'hC3);
        spi_xfer(8'h0F, SIZE, m1);
        spi_xfer(8'hF0, SIZE, m2);
        spi_end();
        assertions++;
        if (m1 !== 8'h3C || m2 !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_miso: got %h %h, required 3c c3", m1, m2);
        end
        assertions++;
        if (rx_seen - rx0 != 2 || und_seen != und0) begin
            failures++;
            $display("FAIL b2b_counts: rx=%0d und=%0d, required 2 0", rx_seen - rx0, und_seen - und0);
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_underrun();
        logic [SIZE-1:0] m;
        int rx0, und0;
        assertions++;
        if (tx_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_precond: tx_ready_o=%b, required 1", tx_ready_o);
        end
        rx0  = rx_seen;
        und0 = und_seen;
        rx_exp_q.push_back(8'h96);
        spi_begin();
        spi_xfer(8'h96, SIZE, m);
        spi_end();
        assertions++;
        if (m !== 8'h00) begin
            failures++;
            $display("FAIL underrun_miso: got %h, required 00", m);
        end
        assertions++;
        if (und_seen - und0 != 1 || rx_seen - rx0 != 1) begin
            failures++;
            $display("FAIL underrun_counts: und=%0d rx=%0d, required 1 1", und_seen - und0, rx_seen - rx0);
        end
        check_queue_empty("underrun");
    endtask

    task automatic test_abort();
        logic [SIZE-1:0] m;
        int rx0, ab0;
        write_tx(8'h11);
        rx0 = rx_seen;
        ab0 = abort_seen;
        spi_begin();
        spi_xfer(8'hFF, 5, m);
        cs = 1'b1;
        clks(4);
        assertions++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: busy_o=%b 4 cycles after CS rise, required 0", busy_o);
        end
        clks(HALF);
        sclk = 1'b0;
        mosi = 1'b0;
        clks(HALF);
        assertions++;
        if (abort_seen - ab0 != 1 || rx_seen != rx0) begin
            failures++;
            $display("FAIL abort_counts: abort=%0d rx=%0d, required 1 0", abort_seen - ab0, rx_seen - rx0);
        end
        assertions++;
        if (rx_data_o !== 8'h96) begin
            failures++;
            $display("FAIL abort_rx_hold: rx_data_o=%h, required 96", rx_data_o);
        end
    endtask

    task automatic test_tx_blocked();
        logic [SIZE-1:0] m;
        int und0;
        write_tx(8'hA7);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        clks(3);
        tx_valid = 1'b0;
        assertions++;
        if (tx_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL blocked_ready: tx_ready_o=%b, required 0", tx_ready_o);
        end
        und0 = und_seen;
        rx_exp_q.push_back(8'h00);
        spi_begin();
        spi_xfer(8'h00, SIZE, m);
        spi_end();
        assertions++;
        if (m !== 8'hA7 || und_seen != und0) begin
            failures++;
            $display("FAIL blocked_miso: got %h und=%0d, required a7 0", m, und_seen - und0);
        end
        check_queue_empty("blocked");
    endtask

    task automatic test_reset_midframe();
        logic [SIZE-1:0] m;
        int rx0;
        write_tx(8'h81);
        rx0 = rx_seen;
        spi_begin();
        spi_xfer(8'hFF, 3, m);
        sclk = 1'b0;
        clks(2);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        clks(3);
        rst = 1'b1;
        clks(20);
        assertions++;
        if (busy_o !== 1'b0 || rx_seen != rx0) begin
            failures++;
            $display("FAIL midframe_no_start: busy=%b rx=%0d, required 0 0", busy_o, rx_seen - rx0);
        end
        cs = 1'b1;
        clks(HALF);
        write_tx(8'hE1);
        rx_exp_q.push_back(8'h7E);
        spi_begin();
        spi_xfer(8'h7E, SIZE, m);
        spi_end();
        assertions++;
        if (m !== 8'hE1 || rx_data_o !== 8'h7E) begin
            failures++;
            $display("FAIL midframe_recover: miso=%h rx=%h, required e1 7e", m, rx_data_o);
        end
        check_queue_empty("midframe");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_tx_blocked();
        test_reset_midframe();
        clks(4);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave: the far end of the link driven by our SPI master. It oversamples SCLK, CS and MOSI in the system clock domain, shifts in SIZE-bit words, and presents each received word on a one-cycle valid strobe. It shifts out a word supplied through a one-entry transmit buffer with a valid/ready handshake. It is used for loopback against the master on the FPGA and as a standalone peripheral endpoint.

Parameters:
SIZE, 8, bits per SPI word (SIZE >= 2)

Ports:
clk  input  1  system clock; all logic is on posedge clk
rst  input  1  asynchronous, active-low reset (rst = 0 resets)
tx_data_i  input  SIZE  word to transmit on MISO
tx_valid_i  input  1  tx_data_i is valid
tx_ready_o  output  1  transmit buffer empty; a write is accepted when tx_valid_i & tx_ready_o
rx_data_o  output  SIZE  last complete word received on MOSI
rx_valid_o  output  1  one-cycle strobe: rx_data_o updated
busy_o  output  1  CS is asserted (synchronized) and a frame is in progress
underrun_o  output  1  one-cycle strobe: a word load found the transmit buffer empty
abort_o  output  1  one-cycle strobe: CS rose with a partial word (1..SIZE-1 bits)
SCLK  input  1  SPI clock from master, asynchronous to clk
CS  input  1  SPI chip select, active-low, asynchronous
MOSI  input  1  SPI data from master
MISO  output  1  SPI data to master

Behaviour:
- Reset values: tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, underrun_o=0, abort_o=0, MISO=0. Bit counter=0. Transmit buffer empty. Synchronizers are loaded with idle levels: SCLK=0, CS=1, MOSI=0.
- Synchronization: SCLK, CS and MOSI each pass through two flops. A third flop on SCLK and on CS provides edge detection. All SPI actions occur on the clk edge where a synchronized edge is detected.
- Timing requirement (documented, not checked): SCLK high and low phases each >= 3 clk periods; CS setup/hold to SCLK >= 3 clk periods.
- States: IDLE, LOAD, SHIFT.
- IDLE: busy_o=0, MISO=0. On a CS falling edge, go to LOAD.
- LOAD (one cycle):
  - If the transmit buffer is full, copy it to the tx shift register and mark the buffer empty (tx_ready_o=1 from the next cycle).
  - Otherwise load all zeros and pulse underrun_o.
  - MISO = tx shift register MSB from the next cycle onward. Bit counter=0, busy_o=1. Go to SHIFT.
- SHIFT:
  - On a SCLK rising edge: shift MOSI (synced) into the rx shift register LSB-side and increment the bit counter.
  - When the counter reaches SIZE: rx_data_o <= completed word, rx_valid_o=1 for one cycle, counter <= 0.
  - On a SCLK falling edge with counter != 0: shift the tx register left and drive the next bit on MISO.
  - On a SCLK falling edge with counter == 0 (word boundary, CS still low): perform the LOAD action in place, so back-to-back words are supported.
- CS rising edge in any non-IDLE state:
  - Go to IDLE and set MISO=0.
  - If counter is 1..SIZE-1: pulse abort_o, discard the partial word, leave rx_data_o unchanged, no rx_valid_o.
  - If counter is 0: no strobe.
  - CS rising has priority over a same-cycle SCLK edge.
- Transmit buffer:
  - A write is accepted when tx_valid_i & tx_ready_o; tx_ready_o drops the next cycle.
  - A write arriving in the same cycle as a load is not bypassed. The load sees the pre-write buffer state; the new word waits for the next load.
- Latency: rx_valid_o asserts 4 clk cycles after the SIZE-th SCLK rising edge at the pin. The first MISO bit is valid 4 clk cycles after CS falls at the pin.
- Reset mid-frame: everything returns to reset values immediately. After release, the block waits for a fresh CS falling edge; a CS already low at release is not treated as a frame start.

Decomposition:
- spi_pkg: state enum typedef (IDLE/LOAD/SHIFT) and the synchronizer depth constant (2).
- Sub-module spi_sync: a 2-flop synchronizer plus edge-detect register, with a parameterized reset value. Instantiated for SCLK and CS; MOSI uses synchronization only.

Test Plan:
- Buffer 0x55, then master sends 0xA5 -> one rx_valid_o with rx_data_o=0xA5; MISO sampled at SCLK rises = 0,1,0,1,0,1,0,1; underrun_o never pulses.
- Buffer 0x3C; master sends 0x0F then 0xF0 under one CS low; 0xC3 written after the first load -> rx strobes 0x0F then 0xF0; MISO words 0x3C then 0xC3.
- Empty buffer at CS fall -> underrun_o one-cycle pulse; MISO all 0s for the word; rx still receives the master's word.
- CS raised after 5 SCLK rising edges -> abort_o one-cycle pulse, no rx_valid_o, rx_data_o keeps the prior value, busy_o=0 within 4 cycles.
- rst=0 asserted mid-word, released with CS low -> all outputs at reset values; the next full CS-low frame receives correctly.
- Write with tx_valid_i=1 while tx_ready_o=0 -> not accepted; buffer contents unchanged.
